gnn_frame_sequencer: RTL and testbench
======================================

Name: gnn_frame_sequencer

Overview:
- Sequences the 4-node, 2-layer GNN datapath (four shared-weight dnn nodes with neighbour aggregation).
- Accepts node feature vectors one node per beat on a valid/ready stream, buffers a full 4-node frame, and fires the datapath with a one-cycle in_ready pulse.
- Captures the eight per-node results as their ready flags arrive, then streams them out one node per beat.
- Includes a timeout watchdog so a hung datapath cannot deadlock the frame.

Parameters:
- TIMEOUT, 64, max cycles in WAIT (counted from the cycle after the fire pulse) before giving up on missing results
- CNT_W, 7, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- s_valid  in  1  input feature beat valid
- s_ready  out  1  sequencer can accept a feature beat
- s_x  in  20  {x3,x2,x1,x0} of the current node, each 5-bit signed; beats arrive in node order 0,1,2,3
- dp_in_ready  out  1  fire pulse to the datapath
- dp_x  out  80  buffered features; node n occupies bits [20n+19:20n], packed as in s_x
- dp_w_en  out  1  high from FIRE through WAIT; the datapath weights must stay stable while high
- dp_out  in  168  {out1,out0} per node, 21-bit signed each; node n occupies bits [42n+41:42n]
- dp_out_rdy  in  8  {out1_ready,out0_ready} per node; node n occupies bits [2n+1:2n]
- m_valid  out  1  result beat valid
- m_ready  in  1  downstream accepts the result beat
- m_node  out  2  node index of the current result beat
- m_out0  out  21  node's out0, signed
- m_out1  out  21  node's out1, signed
- frame_done  out  1  one-cycle pulse when the last result beat is accepted
- err_timeout  out  1  sticky; set when any frame times out

Behaviour:
- Reset: when rst_n=0 at a clk edge, the block returns to LOAD from any state.
  - Reset values: s_ready=1, dp_in_ready=0, dp_w_en=0, dp_x=0, m_valid=0, m_node=0, m_out0=0, m_out1=0, frame_done=0, err_timeout=0.
  - Reset also clears the load count, wait counter, capture mask and result buffer.
  - A partially loaded or in-flight frame is discarded.
- LOAD:
  - s_ready=1.
  - On s_valid&s_ready, s_x is written into feature slot load_cnt, then load_cnt increments.
  - After the 4th beat is accepted, go to FIRE; s_ready drops in the cycle after that acceptance.
- FIRE (1 cycle):
  - dp_in_ready=1 and dp_w_en=1.
  - Clear the capture mask and result buffer; zero the wait counter; go to WAIT.
- WAIT:
  - dp_w_en=1; dp_x is held constant.
  - Each cycle, for every bit i with dp_out_rdy[i]=1 and mask[i]=0, capture the matching 21-bit field and set mask[i].
  - Capture is first-seen only; later ready pulses do not overwrite. dp_out_rdy is ignored in the FIRE cycle itself.
  - Mask all ones (including bits captured that same cycle) -> DRAIN next cycle.
  - Otherwise the counter increments; when the counter reaches TIMEOUT with mask incomplete, set err_timeout and go to DRAIN. Uncaptured results read as 0.
  - If the mask completes in the same cycle the counter hits TIMEOUT, completion wins and err_timeout is not set.
- DRAIN:
  - m_valid=1, m_node=drain_idx (starting at 0), m_out0/m_out1 = captured pair for that node.
  - Outputs are registered and stable while m_valid&!m_ready.
  - On m_ready, drain_idx increments.
  - On acceptance of node 3: frame_done=1 for exactly 1 cycle, m_valid=0 next cycle, return to LOAD with s_ready=1.
- Throughput: no overlap between frames. Minimum frame = 4 load + 1 fire + 1 wait + 4 drain cycles.
- Arithmetic: none in the block. Values pass through bit-exact with sign preserved.
- err_timeout clears only on reset.

Test Plan:
- Nominal frame: load node features x=(1,2,3,4),(5,6,7,8),(-1,-2,-3,-4),(0,0,0,15); datapath model returns out0=100n+1, out1=100n+2 three cycles after the fire pulse -> exactly one dp_in_ready pulse; dp_x matches the input packing; beats (n,100n+1,100n+2) for n=0..3; frame_done once; err_timeout=0.
- Skewed and repeated ready: node 2 out1_ready asserts at cycle 40, and node 0 out0_ready pulses twice with different data (7, then 9) -> captured value 7, DRAIN entered at cycle 41, no timeout.
- Timeout: node 3 out1_ready never asserts, TIMEOUT=64 -> err_timeout=1 after 64 WAIT cycles; node-3 beat carries m_out1=0; the next frame still runs and err_timeout stays 1.
- Backpressure: m_ready low for 5 cycles on every beat, plus s_valid gaps during LOAD -> no data loss or duplication; outputs stable while stalled; s_ready=0 in FIRE, WAIT and DRAIN.
- Reset mid-operation: rst_n=0 for 1 cycle during WAIT, and again after 2 DRAIN beats -> all outputs at reset values next cycle; the next full frame completes correctly.
- Completion vs timeout tie: last ready bit arrives exactly at counter=TIMEOUT -> DRAIN with full data, err_timeout=0.

Source files
------------

// File: rtl/gnn_frame_sequencer.sv
// gnn_frame_sequencer: buffers a 4-node feature frame, fires the shared-weight GNN datapath,
// collects the eight per-node results (with a watchdog) and streams them out one node per beat.
`default_nettype none

module gnn_frame_sequencer #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [19:0]  s_x,
  output logic         dp_in_ready,
  output logic [79:0]  dp_x,
  output logic         dp_w_en,
  input  logic [167:0] dp_out,
  input  logic [7:0]   dp_out_rdy,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [1:0]   m_node,
  output logic [20:0]  m_out0,
  output logic [20:0]  m_out1,
  output logic         frame_done,
  output logic         err_timeout
);

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FIRE  = 2'd1,
    WAIT  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t             state;
  logic [1:0]         load_cnt;
  logic [CNT_W-1:0]   wait_cnt;
  logic [7:0]         mask;
  logic [7:0]         mask_n;
  logic [7:0][20:0]   res;
  logic [7:0][20:0]   res_n;
  logic [1:0]         next_node;

  assign next_node = m_node + 2'd1;

  // Result field i sits at dp_out[21*i +: 21]; first ready pulse wins, later ones are ignored.
  always_comb begin
    mask_n = mask;
    res_n  = res;
    if (state == WAIT) begin
      for (int i = 0; i < 8; i++) begin
        if (dp_out_rdy[i] && !mask[i]) begin
          mask_n[i] = 1'b1;
          res_n[i]  = dp_out[21*i +: 21];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= LOAD;
      load_cnt    <= 2'd0;
      wait_cnt    <= '0;
      mask        <= '0;
      res         <= '0;
      s_ready     <= 1'b1;
      dp_in_ready <= 1'b0;
      dp_w_en     <= 1'b0;
      dp_x        <= '0;
      m_valid     <= 1'b0;
      m_node      <= 2'd0;
      m_out0      <= '0;
      m_out1      <= '0;
      frame_done  <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        LOAD: begin
          if (s_valid && s_ready) begin
            for (int n = 0; n < 4; n++) begin
              if (load_cnt == 2'(n)) dp_x[20*n +: 20] <= s_x;
            end
            load_cnt <= load_cnt + 2'd1;
            if (load_cnt == 2'd3) begin
              state       <= FIRE;
              s_ready     <= 1'b0;
              dp_in_ready <= 1'b1;
              dp_w_en     <= 1'b1;
            end
          end
        end
        FIRE: begin
          dp_in_ready <= 1'b0;
          mask        <= '0;
          res         <= '0;
          wait_cnt    <= '0;
          state       <= WAIT;
        end
        WAIT: begin
          mask     <= mask_n;
          res      <= res_n;
          wait_cnt <= wait_cnt + 1'b1;
          // The TIMEOUT-th WAIT cycle is the last one; completion in that cycle beats the timeout.
          if ((&mask_n) || (wait_cnt == CNT_W'(TIMEOUT - 1))) begin
            if (!(&mask_n)) err_timeout <= 1'b1;
            state   <= DRAIN;
            dp_w_en <= 1'b0;
            m_valid <= 1'b1;
            m_node  <= 2'd0;
            m_out0  <= res_n[0];
            m_out1  <= res_n[1];
          end
        end
        DRAIN: begin
          if (m_ready) begin
            if (m_node == 2'd3) begin
              m_valid    <= 1'b0;
              frame_done <= 1'b1;
              s_ready    <= 1'b1;
              state      <= LOAD;
            end else begin
              m_node <= next_node;
              m_out0 <= res[{next_node, 1'b0}];
              m_out1 <= res[{next_node, 1'b1}];
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_gnn_frame_sequencer.sv
// tb_gnn_frame_sequencer: scoreboard bench driving frames with a scheduled datapath model.
`default_nettype none

module tb_gnn_frame_sequencer;

  localparam int TIMEOUT = 64;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [19:0]  s_x = '0;
  logic         dp_in_ready;
  logic [79:0]  dp_x;
  logic         dp_w_en;
  logic [167:0] dp_out = '0;
  logic [7:0]   dp_out_rdy = '0;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic [1:0]   m_node;
  logic [20:0]  m_out0;
  logic [20:0]  m_out1;
  logic         frame_done;
  logic         err_timeout;

  gnn_frame_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x),
    .dp_in_ready(dp_in_ready), .dp_x(dp_x), .dp_w_en(dp_w_en), .dp_out(dp_out),
    .dp_out_rdy(dp_out_rdy), .m_valid(m_valid), .m_ready(m_ready), .m_node(m_node),
    .m_out0(m_out0), .m_out1(m_out1), .frame_done(frame_done), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  node;
    logic [20:0] o0;
    logic [20:0] o1;
  } beat_t;

  beat_t       exp_q[$];
  int          total = 0;
  int          bad = 0;
  int          fire_cnt = 0;
  int          done_cnt = 0;
  int          arr[8];
  logic [20:0] val[8];
  int          dupk = -1;
  logic [20:0] dupv = '0;
  logic [19:0] feat[4];
  bit          fire_junk = 1'b0;
  bit          exp_err = 1'b0;

  always @(negedge clk) begin
    if (dp_in_ready) fire_cnt++;
    if (frame_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [95:0] got, input logic [95:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] pk(input int a, input int b, input int c, input int d);
    return {5'(d), 5'(c), 5'(b), 5'(a)};
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; s_valid = 1'b0; m_ready = 1'b0; dp_out_rdy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_err = 1'b0;
    chk("rst_s_ready", s_ready, 1);
    chk("rst_dp_in_ready", dp_in_ready, 0);
    chk("rst_dp_w_en", dp_w_en, 0);
    chk("rst_dp_x", dp_x, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_node", m_node, 0);
    chk("rst_m_out0", m_out0, 0);
    chk("rst_m_out1", m_out1, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_err_timeout", err_timeout, 0);
  endtask

  task automatic drive_dp(input int k);
    for (int i = 0; i < 8; i++) begin
      if (k == arr[i]) begin
        dp_out_rdy[i] = 1'b1; dp_out[21*i +: 21] = val[i];
      end else if (i == 0 && k == dupk) begin
        dp_out_rdy[i] = 1'b1; dp_out[21*i +: 21] = dupv;
      end else begin
        dp_out_rdy[i] = 1'b0; dp_out[21*i +: 21] = 21'($urandom);
      end
    end
  endtask

  task automatic check_beat(input beat_t b);
    chk("m_valid", m_valid, 1);
    chk("m_node", m_node, b.node);
    chk("m_out0", m_out0, b.o0);
    chk("m_out1", m_out1, b.o1);
    chk("drain_s_ready", s_ready, 0);
  endtask

  // abort: 0 = full frame, 1 = reset in WAIT, 2 = reset after two accepted beats
  task automatic run_frame(input int gap, input int stall, input int abort);
    int n, guard, k, exp_k, maxa, f0, d0;
    bit full, acc;
    beat_t b;
    logic [79:0] px;
    f0 = fire_cnt; d0 = done_cnt;
    full = 1'b1; maxa = 0;
    for (int i = 0; i < 8; i++) begin
      if (arr[i] < 0 || arr[i] >= TIMEOUT) full = 1'b0;
      else if (arr[i] > maxa) maxa = arr[i];
    end
    exp_k = full ? maxa + 1 : TIMEOUT;
    if (!full) exp_err = 1'b1;
    for (int nd = 0; nd < 4; nd++) begin
      b.node = 2'(nd);
      b.o0 = (arr[2*nd] >= 0 && arr[2*nd] < TIMEOUT) ? val[2*nd] : 21'd0;
      b.o1 = (arr[2*nd+1] >= 0 && arr[2*nd+1] < TIMEOUT) ? val[2*nd+1] : 21'd0;
      exp_q.push_back(b);
    end
    px = {feat[3], feat[2], feat[1], feat[0]};

    n = 0; guard = 0;
    while (n < 4 && guard < 100) begin
      if (gap > 0 && $urandom_range(0, 2) == 0) s_valid = 1'b0;
      else begin s_valid = 1'b1; s_x = feat[n]; end
      acc = s_valid && s_ready;
      @(negedge clk);
      if (acc) n++;
      guard++;
    end
    s_valid = 1'b0; s_x = 20'($urandom);
    chk("load_beats", n, 4);
    chk("fire_pulse", dp_in_ready, 1);
    chk("fire_w_en", dp_w_en, 1);
    chk("fire_s_ready", s_ready, 0);
    chk("dp_x", dp_x, px);
    if (fire_junk) begin
      dp_out_rdy = '1;
      for (int i = 0; i < 8; i++) dp_out[21*i +: 21] = 21'($urandom);
    end else dp_out_rdy = '0;
    @(negedge clk);

    k = 0;
    while (!m_valid && k < 200) begin
      chk("wait_w_en", dp_w_en, 1);
      chk("wait_s_ready", s_ready, 0);
      chk("wait_dp_x", dp_x, px);
      drive_dp(k);
      if (abort == 1 && k == 5) begin do_reset(); return; end
      @(negedge clk);
      k++;
    end
    dp_out_rdy = '0;
    chk("drain_cycle", k, exp_k);
    chk("err_timeout", err_timeout, exp_err);
    chk("drain_w_en", dp_w_en, 0);

    for (int bt = 0; bt < 4; bt++) begin
      b = exp_q[0];
      check_beat(b);
      m_ready = 1'b0;
      repeat (stall) begin
        @(negedge clk);
        check_beat(b);
      end
      if (abort == 2 && bt == 2) begin do_reset(); return; end
      m_ready = 1'b1;
      @(negedge clk);
      void'(exp_q.pop_front());
      m_ready = 1'b0;
    end
    chk("frame_done", frame_done, 1);
    chk("end_m_valid", m_valid, 0);
    chk("end_s_ready", s_ready, 1);
    chk("end_err", err_timeout, exp_err);
    @(negedge clk);
    chk("frame_done_pulse", frame_done, 0);
    chk("frame_done_cnt", done_cnt - d0, 1);
    chk("fire_cnt", fire_cnt - f0, 1);
  endtask

  task automatic rand_sched(input int maxd);
    for (int i = 0; i < 8; i++) begin
      arr[i] = $urandom_range(0, maxd);
      val[i] = 21'($urandom);
    end
    for (int n = 0; n < 4; n++) feat[n] = 20'($urandom);
    dupk = -1;
    fire_junk = 1'b0;
  endtask

  initial begin
    do_reset();

    // nominal frame; junk ready/data during FIRE must be ignored
    feat[0] = pk(1, 2, 3, 4);   feat[1] = pk(5, 6, 7, 8);
    feat[2] = pk(-1, -2, -3, -4); feat[3] = pk(0, 0, 0, 15);
    for (int n = 0; n < 4; n++) begin
      arr[2*n] = 2; arr[2*n+1] = 2;
      val[2*n] = 21'(100*n + 1); val[2*n+1] = 21'(100*n + 2);
    end
    dupk = -1; fire_junk = 1'b1;
    run_frame(0, 0, 0);

    // skewed arrival and repeated ready on node 0 out0
    rand_sched(20);
    arr[5] = 40; arr[0] = 1; val[0] = 21'd7; dupk = 5; dupv = 21'd9;
    run_frame(0, 1, 0);

    // timeout: node 3 out1 never ready, then a clean frame keeps the sticky flag
    rand_sched(20);
    arr[7] = -1;
    run_frame(0, 0, 0);
    rand_sched(10);
    run_frame(0, 0, 0);

    // backpressure and load gaps
    rand_sched(10);
    run_frame(1, 5, 0);

    // reset in WAIT, then a full frame
    rand_sched(10);
    run_frame(0, 0, 1);
    rand_sched(10);
    run_frame(1, 0, 0);

    // reset after two drained beats, then a full frame
    rand_sched(10);
    run_frame(0, 2, 2);
    rand_sched(10);
    run_frame(0, 1, 0);

    // completion in the same cycle the watchdog expires
    rand_sched(50);
    arr[3] = TIMEOUT - 1;
    run_frame(0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
